// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory port between instruction
// fetch (imem) and load/store (dmem). Data wins contention, but a starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive losses. Read
// data is steered back to the issuing port and held until its next read.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction-fetch port
  input  logic [31:0] imem_address,
  input  logic        imem_enable,
  output logic [31:0] imem_data,
  output logic        imem_wait,
  // Load/store port
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic        dmem_write_enable,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_byteen,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  // Shared memory port
  output logic [31:0] mem_address,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_q
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  logic [CNT_W-1:0]  r_starve_cnt;
  owner_t            r_rd_owner;
  logic [DATA_W-1:0] r_i_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_d_store;

  // Grant decision: data first, fetch forced once the starve counter hits the limit
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!reset) begin
      if (imem_enable && dmem_enable) begin
        if (r_starve_cnt >= LIMIT) begin
          w_grant_i = 1'b1;
        end else begin
          w_grant_d = 1'b1;
        end
      end else if (imem_enable) begin
        w_grant_i = 1'b1;
      end else if (dmem_enable) begin
        w_grant_d = 1'b1;
      end
    end
  end

  assign w_d_store = w_grant_d && dmem_write_enable;

  // Shared-port drive and per-port stall indication
  always_comb begin
    mem_enable       = w_grant_i || w_grant_d;
    mem_address      = ADDR_W'(0);
    mem_write_enable = w_d_store;
    mem_write_data   = DATA_W'(0);
    mem_byteen       = BE_W'(0);
    if (w_grant_d) begin
      mem_address = dmem_address;
      mem_byteen  = dmem_byteen;
      if (dmem_write_enable) begin
        mem_write_data = dmem_write_data;
      end
    end else if (w_grant_i) begin
      mem_address = imem_address;
    end
    imem_wait = reset || (imem_enable && !w_grant_i);
    dmem_wait = reset || (dmem_enable && !w_grant_d);
  end

  // Return path: live mem_q in the cycle after the owner's read, held value otherwise
  always_comb begin
    imem_data      = r_i_hold;
    dmem_read_data = r_d_hold;
    if (reset) begin
      imem_data      = DATA_W'(0);
      dmem_read_data = DATA_W'(0);
    end else begin
      if (r_rd_owner == OWN_IMEM) imem_data = mem_q;
      if (r_rd_owner == OWN_DMEM) dmem_read_data = mem_q;
    end
  end

  // Starve counter, read-owner tracking and per-port read-data holding registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= CNT_W'(0);
      r_rd_owner   <= OWN_NONE;
      r_i_hold     <= DATA_W'(0);
      r_d_hold     <= DATA_W'(0);
    end else begin
      // Fetch losing counts up (saturating); fetch granted or idle clears it
      if (!imem_enable || w_grant_i) begin
        r_starve_cnt <= CNT_W'(0);
      end else if (r_starve_cnt < LIMIT) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      if (w_grant_i) begin
        r_rd_owner <= OWN_IMEM;
      end else if (w_grant_d && !dmem_write_enable) begin
        r_rd_owner <= OWN_DMEM;
      end else begin
        r_rd_owner <= OWN_NONE;
      end

      if (r_rd_owner == OWN_IMEM) r_i_hold <= mem_q;
      if (r_rd_owner == OWN_DMEM) r_d_hold <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with STARVE_LIMIT=4: reset gating, single
// fetch, read steering, store pass-through, contention, withdrawn fetch and
// reset in the middle of a load.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_enable;
  logic [31:0] imem_data;
  logic        imem_wait;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic        dmem_write_enable;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;
  logic [31:0] mem_address;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_q;

  int n_cmp;
  int n_err;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_enable      (imem_enable),
    .imem_data        (imem_data),
    .imem_wait        (imem_wait),
    .dmem_address     (dmem_address),
    .dmem_enable      (dmem_enable),
    .dmem_write_enable(dmem_write_enable),
    .dmem_write_data  (dmem_write_data),
    .dmem_byteen      (dmem_byteen),
    .dmem_read_data   (dmem_read_data),
    .dmem_wait        (dmem_wait),
    .mem_address      (mem_address),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_byteen       (mem_byteen),
    .mem_q            (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge so new inputs apply to the next cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs change
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    imem_enable       = 1'b0;
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
    dmem_write_data   = 32'h0;
    dmem_byteen       = 4'h0;
  endtask

  // Both ports request for cnt cycles from a cleared starve counter: fetch wins every 5th
  task automatic contention(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      next_cycle();
      imem_enable       = 1'b1;
      imem_address      = 32'h0000_0040;
      dmem_enable       = 1'b1;
      dmem_write_enable = 1'b0;
      dmem_address      = 32'h0000_0080;
      mem_q             = 32'h1000_0000 + 32'(k);
      settle();
      chk($sformatf("%s_iwait%0d", tag, k), 32'(imem_wait), (k % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("%s_dwait%0d", tag, k), 32'(dmem_wait), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("%s_addr%0d", tag, k), mem_address,
          (k % 5 == 4) ? 32'h0000_0040 : 32'h0000_0080);
      if (k > 0 && ((k - 1) % 5 == 4))
        chk($sformatf("%s_idata%0d", tag, k), imem_data, 32'h1000_0000 + 32'(k));
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    imem_address = 32'h0;
    dmem_address = 32'h0;
    mem_q        = 32'h0;
    idle_inputs();

    // Reset gating with both ports requesting, dmem as a store
    next_cycle();
    imem_enable       = 1'b1;
    dmem_enable       = 1'b1;
    dmem_write_enable = 1'b1;
    dmem_write_data   = 32'hFFFF_FFFF;
    dmem_byteen       = 4'hF;
    mem_q             = 32'h5A5A_5A5A;
    settle();
    chk("rst_iwait", 32'(imem_wait), 32'd1);
    chk("rst_dwait", 32'(dmem_wait), 32'd1);
    chk("rst_men",   32'(mem_enable), 32'd0);
    chk("rst_mwe",   32'(mem_write_enable), 32'd0);
    chk("rst_idata", imem_data, 32'h0);
    chk("rst_ddata", dmem_read_data, 32'h0);

    // Single fetch
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    imem_enable  = 1'b1;
    imem_address = 32'h0000_0010;
    settle();
    chk("sf_iwait", 32'(imem_wait), 32'd0);
    chk("sf_men",   32'(mem_enable), 32'd1);
    chk("sf_addr",  mem_address, 32'h0000_0010);
    chk("sf_mwe",   32'(mem_write_enable), 32'd0);
    chk("sf_be",    32'(mem_byteen), 32'd0);
    chk("sf_wdata", mem_write_data, 32'h0);
    next_cycle();
    imem_enable = 1'b0;
    mem_q       = 32'hDEAD_BEEF;
    settle();
    chk("sf_idata", imem_data, 32'hDEAD_BEEF);
    chk("sf_men_idle", 32'(mem_enable), 32'd0);
    next_cycle();
    mem_q = 32'h1234_5678;
    settle();
    chk("sf_ihold", imem_data, 32'hDEAD_BEEF);

    // Data steering: fetch then load on consecutive cycles
    next_cycle();
    imem_enable  = 1'b1;
    imem_address = 32'h0000_0100;
    settle();
    chk("st_iaddr", mem_address, 32'h0000_0100);
    next_cycle();
    imem_enable  = 1'b0;
    dmem_enable  = 1'b1;
    dmem_address = 32'h0000_0200;
    mem_q        = 32'hAAAA_0000;
    settle();
    chk("st_idata", imem_data, 32'hAAAA_0000);
    chk("st_daddr", mem_address, 32'h0000_0200);
    chk("st_dwait", 32'(dmem_wait), 32'd0);
    next_cycle();
    dmem_enable = 1'b0;
    mem_q       = 32'h5555_FFFF;
    settle();
    chk("st_ddata", dmem_read_data, 32'h5555_FFFF);
    chk("st_ihold", imem_data, 32'hAAAA_0000);

    // Store pass-through; load data must survive it
    next_cycle();
    dmem_enable       = 1'b1;
    dmem_write_enable = 1'b1;
    dmem_address      = 32'h8000_0004;
    dmem_write_data   = 32'h1122_3344;
    dmem_byteen       = 4'b0100;
    mem_q             = 32'hCAFE_F00D;
    settle();
    chk("sw_mwe",   32'(mem_write_enable), 32'd1);
    chk("sw_addr",  mem_address, 32'h8000_0004);
    chk("sw_wdata", mem_write_data, 32'h1122_3344);
    chk("sw_be",    32'(mem_byteen), 32'h4);
    chk("sw_ddata", dmem_read_data, 32'h5555_FFFF);
    next_cycle();
    idle_inputs();
    mem_q = 32'h0BAD_BEEF;
    settle();
    chk("sw_dhold", dmem_read_data, 32'h5555_FFFF);
    chk("sw_ihold", imem_data, 32'hAAAA_0000);

    // Continuous contention
    contention("ct", 12);
    next_cycle();
    idle_inputs();

    // Withdrawn fetch: two lost cycles, then fetch drops its request
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      imem_enable  = 1'b1;
      imem_address = 32'h0000_0300;
      dmem_enable  = 1'b1;
      dmem_address = 32'h0000_0400;
      settle();
      chk($sformatf("wd_iwait%0d", k), 32'(imem_wait), 32'd1);
    end
    next_cycle();
    imem_enable = 1'b0;
    settle();
    chk("wd_dgrant", mem_address, 32'h0000_0400);
    contention("wd", 6);

    // Reset in the cycle after a load issues
    next_cycle();
    idle_inputs();
    dmem_enable  = 1'b1;
    dmem_address = 32'h0000_0500;
    settle();
    chk("rm_dwait", 32'(dmem_wait), 32'd0);
    next_cycle();
    reset       = 1'b1;
    imem_enable = 1'b1;
    mem_q       = 32'h7777_7777;
    settle();
    chk("rm_ddata", dmem_read_data, 32'h0);
    chk("rm_iwait", 32'(imem_wait), 32'd1);
    chk("rm_dwait_rst", 32'(dmem_wait), 32'd1);
    chk("rm_men", 32'(mem_enable), 32'd0);
    next_cycle();
    settle();
    chk("rm_ddata2", dmem_read_data, 32'h0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    settle();
    chk("rm_dhold_clr", dmem_read_data, 32'h0);
    chk("rm_ihold_clr", imem_data, 32'h0);
    contention("rr", 6);

    next_cycle();
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter: shares a single synchronous-read memory port between the instruction-fetch port and the load/store port. It sits between the core and the unified memory array. Data has priority. A starvation counter guarantees forward progress for fetch. Returned read data is steered back to the port that issued the read and held stable until that port's next read.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive cycles fetch may lose arbitration before it is forced a grant (1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- imem_address  in  32  fetch address, held while imem_wait=1
- imem_enable  in  1  fetch request
- imem_data  out  32  fetch read data
- imem_wait  out  1  fetch request not accepted this cycle
- dmem_address  in  32  load/store address, held while dmem_wait=1
- dmem_enable  in  1  load/store request
- dmem_write_enable  in  1  1=store, 0=load
- dmem_write_data  in  32  store data, lane-aligned
- dmem_byteen  in  4  store byte enables
- dmem_read_data  out  32  load read data
- dmem_wait  out  1  load/store request not accepted this cycle
- mem_address  out  32  shared port address
- mem_enable  out  1  shared port clock enable
- mem_write_enable  out  1  shared port write
- mem_write_data  out  32  shared port write data
- mem_byteen  out  4  shared port byte enables
- mem_q  in  32  shared port read data, valid one cycle after mem_enable

## Operation
- Accept rule: a port's request is accepted in cycle N iff its enable=1 and its wait=0 in N. A stalled requester holds enable, address and data unchanged until it is accepted.
- Grant decision is combinational from the enables and the starve counter:
  - neither enabled: no grant, mem_enable=0.
  - one enabled: that port is granted.
  - both enabled, starve_cnt < STARVE_LIMIT: grant dmem, imem_wait=1, starve_cnt += 1.
  - both enabled, starve_cnt == STARVE_LIMIT: grant imem, dmem_wait=1, starve_cnt <= 0.
- starve_cnt clears whenever imem is granted or imem_enable=0. It saturates at STARVE_LIMIT.
- Granted port drives mem_address and mem_enable=1. For imem, mem_write_enable=0 and mem_byteen=0. For dmem, write_enable, write_data and byteen pass through. mem_write_data=0 when not a dmem store.
- rd_owner register (NONE/IMEM/DMEM) records the owner of the read issued this cycle:
  - IMEM on an imem grant.
  - DMEM on a dmem load grant.
  - NONE on a store or no grant.
- Return path:
  - In cycle N+1 with rd_owner=IMEM: imem_data = mem_q, and mem_q is captured into i_hold.
  - Otherwise imem_data = i_hold.
  - Same rule for dmem_read_data and d_hold with rd_owner=DMEM.
- Stores never update d_hold.
- No address decoding, no byte-lane extraction: address and data pass through unchanged.

## Timing
- Grant, wait and mem_* outputs are combinational in the cycle of the request. No added request latency.
- Read latency is one cycle: data for a read accepted in N is on imem_data/dmem_read_data in N+1 and stays there until the same port's next read returns.
- Back-to-back reads from the same or alternating ports are supported every cycle. Throughput is one access per cycle.
- Reset, while asserted:
  - imem_wait=1, dmem_wait=1, mem_enable=0, mem_write_enable=0.
  - rd_owner=NONE, starve_cnt=0, i_hold=0, d_hold=0.
  - imem_data=0, dmem_read_data=0.
- Reset mid-operation: a read issued in N with reset in N+1 is discarded. Outputs read 0 from N+1 on. No write is issued while reset=1.
- Enable dropped while waiting is legal: the request is withdrawn, and starve_cnt clears if it was imem.

## Test plan
- Single fetch: imem_enable=1, addr 0x0000_0010, mem_q=0xDEADBEEF next cycle -> imem_wait=0, mem_address=0x10, imem_data=0xDEADBEEF in N+1 and held while imem_enable=0.
- Contention, STARVE_LIMIT=4: both enabled continuously -> dmem granted cycles 0-3, imem granted cycle 4 with dmem_wait=1, dmem granted cycle 5, pattern repeats.
- Store pass-through: dmem store addr 0x8000_0004, data 0x11223344, byteen 4'b0100 -> mem_write_enable=1 with identical fields. d_hold and dmem_read_data unchanged next cycle.
- Data steering: imem read (mem_q=0xAAAA0000) then dmem load (mem_q=0x5555FFFF) on consecutive cycles -> imem_data=0xAAAA0000 and dmem_read_data=0x5555FFFF, each stable afterwards.
- Reset mid-read: issue dmem load in N, assert reset in N+1 -> dmem_read_data=0, both waits=1, mem_enable=0 during reset. After release, starve_cnt restarts from 0.
- Withdrawn fetch: imem stalled 2 cycles, imem_enable drops -> starve_cnt returns to 0. The next contention gives dmem 4 grants before imem.
